// File: rtl/alu_sequencer.sv
// Command-driven sequencer for an 8-bit ALU datapath: accumulator, operand, one-hot select and overflow handling.
// Optional ALU_SEQ_SATURATE_EN: a qualified overflow saturates the result and completes normally instead of erroring.
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | parked; on=1 moves to READY; accumulator retained
// READY | cmd_ready=1 while on=1; accepts one command
// EXEC  | ALU inputs driven; non-MULT result sampled at end of cycle
// WAIT  | MULT latency beyond the first cycle, timed by down-counter
// RESP  | response presented until rsp_ready
// ERROR | overflow response presented until rsp_ready
module alu_sequencer #(
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [6:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic             error,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_READY = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam bit         HAS_WAIT  = (MULT_LAT > 1);
  localparam logic [2:0] WAIT_INIT = 3'(HAS_WAIT ? MULT_LAT - 2 : 0);

  state_t     st;
  logic [2:0] cnt;
  logic [6:0] sel_dec;
  logic       qual_ovf;
  logic       sample_now;

  assign state     = st;
  assign cmd_ready = (st == S_READY) && on;
  assign rsp_valid = (st == S_RESP) || (st == S_ERROR);

  assign sel_dec  = 7'(8'd1 << cmd_op);
  // Overflow only means something for the arithmetic ops.
  assign qual_ovf = alu_overflow && (alu_sel[4] || alu_sel[5] || alu_sel[6]);
  assign sample_now = ((st == S_EXEC) && (!alu_sel[6] || !HAS_WAIT)) ||
                      ((st == S_WAIT) && (cnt == 3'd0));

`ifdef ALU_SEQ_SATURATE_EN
  logic [WIDTH-1:0] sat_val;
  assign sat_val = alu_sel[5] ? '0 : '1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= S_OFF;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (st)
        S_OFF: begin
          if (on) st <= S_READY;
        end
        S_READY: begin
          if (!on) begin
            st <= S_OFF;
          end else if (cmd_valid) begin
            error <= 1'b0;
            if (cmd_load) begin
              alu_a     <= cmd_operand;
              rsp_data  <= cmd_operand;
              rsp_error <= 1'b0;
              st        <= S_RESP;
            end else if (cmd_op == 3'd7) begin
              rsp_data  <= alu_a;
              rsp_error <= 1'b1;
              st        <= S_RESP;
            end else begin
              alu_b   <= cmd_operand;
              alu_sel <= sel_dec;
              st      <= S_EXEC;
            end
          end
        end
        S_EXEC, S_WAIT: begin
          if (sample_now) begin
            rsp_data <= alu_result;
            alu_sel  <= '0;
            if (qual_ovf) begin
              error     <= 1'b1;
              rsp_error <= 1'b1;
`ifdef ALU_SEQ_SATURATE_EN
              alu_a    <= sat_val;
              rsp_data <= sat_val;
              st       <= S_RESP;
`else
              st <= S_ERROR;
`endif
            end else begin
              alu_a     <= alu_result;
              rsp_error <= 1'b0;
              st        <= S_RESP;
            end
          end else if (st == S_EXEC) begin
            cnt <= WAIT_INIT;
            st  <= S_WAIT;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP, S_ERROR: begin
          if (rsp_ready) st <= on ? S_READY : S_OFF;
        end
        default: st <= S_OFF;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-driven controller that sequences the 8-bit ALU datapath: the accumulator register, the operand register, the one-hot operation select and overflow handling.
It accepts load/operate commands over a valid/ready handshake, holds the ALU inputs stable for the operation's latency, and writes results back into the accumulator.
It returns each result over a response handshake.
Power and error sequencing uses an OFF/READY/RUN/ERROR scheme: an overflow routes to ERROR, and ERROR returns to READY.

Parameters:
WIDTH, 8, datapath width of accumulator, operand and result
MULT_LAT, 2, cycles the multiplier needs from stable inputs to valid result; legal range 1..7

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
on  in  1  enable; 0 parks the block in OFF
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_load  in  1  1 = load cmd_operand into the accumulator; no ALU op
cmd_op  in  3  operation code: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 illegal
cmd_operand  in  WIDTH  operand B, or load value
alu_a  out  WIDTH  accumulator value driven to the ALU
alu_b  out  WIDTH  operand register driven to the ALU
alu_sel  out  7  one-hot op select; bit n corresponds to cmd_op n
alu_result  in  WIDTH  combinational ALU result
alu_overflow  in  1  ALU overflow/borrow flag
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_data  out  WIDTH  result value
rsp_error  out  1  response carries an error
error  out  1  sticky error flag
state  out  3  current FSM state code

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=OFF, alu_a=0, alu_b=0, alu_sel=0, rsp_valid=0, rsp_data=0, rsp_error=0, error=0, cmd_ready=0.
  - Any in-flight operation and its response are discarded.
- State codes: OFF=0, READY=1, EXEC=2, WAIT=3, RESP=4, ERROR=5. Codes 6 and 7 go to OFF.
- cmd_ready=1 only in READY with on=1. A command is accepted when cmd_valid and cmd_ready are both 1 on a rising edge.
- OFF: on=1 moves to READY on the next edge. Accumulator contents are retained.
- READY with on=0: move to OFF; no command is accepted.
- READY accept with cmd_load=1:
  - alu_a takes cmd_operand, rsp_data takes cmd_operand, rsp_error=0.
  - Move to RESP. error is cleared.
- READY accept with cmd_op=7: rsp_data=alu_a, rsp_error=1, accumulator unchanged, alu_sel stays 0. Move to RESP.
- READY accept with cmd_op 0..6:
  - alu_b takes cmd_operand; alu_sel takes the one-hot of cmd_op. error is cleared.
  - Move to EXEC.
- EXEC lasts one cycle:
  - Non-MULT: alu_result and alu_overflow are sampled at the end of EXEC.
  - MULT: move to WAIT for MULT_LAT-1 cycles using an internal down-counter, then sample. With MULT_LAT=1 there is no WAIT.
- Sampling rules:
  - rsp_data takes alu_result; alu_sel returns to 0.
  - Overflow is qualified only for ADD, SUB and MULT; it is ignored for AND, OR, NOT and XOR.
  - No qualified overflow: alu_a takes alu_result, rsp_error=0, move to RESP.
  - Qualified overflow: the accumulator is unchanged, rsp_data holds the truncated result, rsp_error=1, error is set, move to ERROR.
- alu_sel is nonzero only in EXEC and WAIT. alu_a and alu_b stay stable throughout EXEC and WAIT.
- RESP and ERROR:
  - rsp_valid=1; rsp_data and rsp_error are held stable until rsp_ready=1.
  - After the handshake, go to READY if on=1, else OFF.
  - rsp_ready already 1 when rsp_valid rises completes the handshake in that same cycle.
- Latency, counted from the accept edge to the first cycle with rsp_valid=1:
  - load or illegal op: 1 cycle.
  - logic/ADD/SUB: 2 cycles.
  - MULT: 1+MULT_LAT cycles.
- Command acceptance is not overlapped with responses. Minimum issue interval is 2 cycles for loads and 3 cycles for ops.
- on=0 during EXEC, WAIT, RESP or ERROR: the operation completes and its response is delivered, then the block goes to OFF.
- error stays set through OFF and READY until the next accepted command.

Optional Feature:
ALU_SEQ_SATURATE_EN
- Defined: a qualified overflow saturates instead of erroring.
  - ADD and MULT saturate to all-ones; SUB saturates to 0.
  - alu_a and rsp_data take the saturated value.
  - rsp_error=1 and error is set, but the FSM goes to RESP, not ERROR.
- Undefined: overflow behaviour is exactly as described above, and no saturation logic is present.

Test Plan:
1. Reset low then high, on=1 -> state OFF(0) for 1 cycle, then READY(1); cmd_ready=1 one edge after on rises.
2. Load 0x0F, then ADD 0x01 (alu_overflow=0) -> alu_sel=7'b0010000 in EXEC; rsp_valid 2 cycles after accept; rsp_data=0x10, rsp_error=0; alu_a=0x10.
3. Load 0xC8, MULT 0x02, MULT_LAT=3, alu_result=0x90, alu_overflow=1 -> alu_sel=7'b1000000 for 3 cycles; rsp_valid 4 cycles after accept; rsp_data=0x90, rsp_error=1, error=1, state=ERROR, alu_a remains 0xC8. With ALU_SEQ_SATURATE_EN defined -> rsp_data=0xFF, alu_a=0xFF, state=RESP.
4. cmd_op=7 with alu_a=0x33 -> rsp_valid 1 cycle after accept; rsp_data=0x33, rsp_error=1; alu_sel stays 0; alu_a unchanged.
5. rsp_ready held 0 for 5 cycles after an XOR response, with cmd_valid=1 throughout -> rsp_valid, rsp_data and rsp_error stable; cmd_ready=0; no second accept until 1 cycle after the handshake.
6. on=0 during WAIT -> response still delivered, then state=OFF with alu_a retained. rst pulsed low during EXEC -> all outputs 0 immediately with no clock edge, state=OFF, no response.
